// File: rtl/fta_arbiter.sv
// Bus arbiter: grants one of NCH master channels access to a single FTA bus
// (fixed-priority or round-robin, with a burst hold limit) and routes bus responses back.
package fta_pkg;

  typedef struct packed {
    logic [3:0] channel;
    logic [3:0] id;
  } fta_tid_t;

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [15:0]   sel;
    logic [31:0]   adr;
    logic [127:0]  dat;
    fta_tid_t      tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic          ack;
    logic          rty;
    logic          err;
    fta_tid_t      tid;
    logic [127:0]  dat;
  } fta_cmd_response128_t;

endpackage

module fta_arbiter
  import fta_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MODE    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  fta_cmd_request128_t  req [NCH],
  output fta_cmd_response128_t resp [NCH],
  output fta_cmd_request128_t  fta_req,
  input  fta_cmd_response128_t fta_resp,
  output logic [NCH-1:0]       gnt,
  output logic [15:0]          stray_cnt
);

  localparam int IW = $clog2(NCH);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  // Forced rotation fires during the MAXHOLD-th consecutive grant cycle.
  localparam logic [15:0] HOLD_LIM = (MAXHOLD == 0) ? 16'd0 : 16'(MAXHOLD - 1);

  logic                 state_r, state_s;
  logic [IW-1:0]        gidx_r, gidx_s;
  logic [NCH-1:0]       gnt_r, gnt_s;
  logic [IW-1:0]        ptr_r, ptr_s;
  logic [15:0]          hold_r, hold_s;
  logic [15:0]          stray_r;
  fta_cmd_response128_t rsp_r;

  logic [NCH-1:0]       cyc_s;
  logic [NCH-1:0]       others_s;
  logic [IW-1:0]        win_s;
  logic                 take_s;
  logic                 idle_s;

  function automatic logic [IW-1:0] pick(input logic [NCH-1:0] m, input logic [IW-1:0] start);
    logic [IW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(start) + k) % NCH;
      if (!found && m[idx]) begin
        found = 1'b1;
        w     = IW'(idx);
      end
    end
    return w;
  endfunction

  // Arbitration: choose the next grant owner, pointer and hold count.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cyc_s[i] = req[i].cyc;
    end
    // The current owner never competes, so a release-and-rerequest loses to everyone else.
    others_s = cyc_s & ~gnt_r;
    win_s    = pick(others_s, (MODE == 1) ? ptr_r : {IW{1'b0}});
    take_s   = 1'b0;
    idle_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        take_s = |cyc_s;
      end
      ST_GRANT: begin
        if (!cyc_s[gidx_r]) begin
          take_s = |others_s;
          idle_s = ~(|others_s);
        end else if ((MAXHOLD != 0) && (hold_r >= HOLD_LIM) && (|others_s)) begin
          take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      default: begin
        idle_s = 1'b1;
      end
    endcase

    state_s = state_r;
    gidx_s  = gidx_r;
    gnt_s   = gnt_r;
    ptr_s   = ptr_r;
    hold_s  = hold_r;
    if (take_s) begin
      state_s = ST_GRANT;
      gidx_s  = win_s;
      gnt_s   = {{(NCH-1){1'b0}}, 1'b1} << win_s;
      ptr_s   = (win_s == IW'(NCH - 1)) ? {IW{1'b0}} : win_s + 1'b1;
      hold_s  = 16'd0;
    end else if (idle_s) begin
      state_s = ST_IDLE;
      gnt_s   = '0;
      hold_s  = 16'd0;
    end else if ((state_r == ST_GRANT) && (hold_r != 16'hFFFF)) begin
      hold_s  = hold_r + 16'd1;
    end else begin
      hold_s  = hold_r;
    end
  end

  // Grant state, response register and stray counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      gidx_r  <= '0;
      gnt_r   <= '0;
      ptr_r   <= '0;
      hold_r  <= 16'd0;
      stray_r <= 16'd0;
      rsp_r   <= '0;
    end else begin
      state_r <= state_s;
      gidx_r  <= gidx_s;
      gnt_r   <= gnt_s;
      ptr_r   <= ptr_s;
      hold_r  <= hold_s;
      rsp_r   <= fta_resp;
      if (rsp_r.ack && (int'(rsp_r.tid.channel) >= NCH) && (stray_r != 16'hFFFF)) begin
        stray_r <= stray_r + 16'd1;
      end else begin
        stray_r <= stray_r;
      end
    end
  end

  // Bus request mux: the owner's request passes straight through.
  always_comb begin
    if (state_r == ST_GRANT) begin
      fta_req = req[gidx_r];
    end else begin
      fta_req = '0;
    end
  end

  // Response fan-out: routing follows tid.channel, independent of who holds the grant.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      resp[i]     = '0;
      resp[i].tid = req[i].tid;
      if ((rsp_r.ack || rsp_r.err || rsp_r.rty) && (int'(rsp_r.tid.channel) == i)) begin
        resp[i]     = rsp_r;
        resp[i].rty = (state_r == ST_GRANT) && (gidx_r == IW'(i)) ? rsp_r.rty : 1'b1;
      end else begin
        resp[i].rty = !((state_r == ST_GRANT) && (gidx_r == IW'(i)));
      end
    end
  end

  assign gnt       = gnt_r;
  assign stray_cnt = stray_r;

endmodule

// File: tb/tb_fta_arbiter.sv
// Directed bench for fta_arbiter: round robin, fixed priority, hold limit,
// response routing, stray counting and mid-burst reset.
module tb_fta_arbiter;
  import fta_pkg::*;

  logic                 clk;
  logic                 rst;
  fta_cmd_request128_t  req  [4];
  fta_cmd_request128_t  req0 [4];
  fta_cmd_response128_t resp [4];
  fta_cmd_response128_t resp0 [4];
  fta_cmd_request128_t  fta_req, fta_req0;
  fta_cmd_response128_t fta_resp;
  logic [3:0]           gnt, gnt0;
  logic [15:0]          stray_cnt, stray_cnt0;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_g;

  fta_arbiter #(.NCH(4), .MODE(1), .MAXHOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .resp(resp), .fta_req(fta_req),
    .fta_resp(fta_resp), .gnt(gnt), .stray_cnt(stray_cnt)
  );

  fta_arbiter #(.NCH(4), .MODE(0), .MAXHOLD(16)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .resp(resp0), .fta_req(fta_req0),
    .fta_resp(fta_resp), .gnt(gnt0), .stray_cnt(stray_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cyc(input logic [3:0] v);
    for (int i = 0; i < 4; i++) req[i].cyc = v[i];
  endtask

  task automatic set_cyc0(input logic [3:0] v);
    for (int i = 0; i < 4; i++) req0[i].cyc = v[i];
  endtask

  function automatic logic [3:0] rty_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = resp[i].rty;
    return v;
  endfunction

  function automatic logic [3:0] ack_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = resp[i].ack;
    return v;
  endfunction

  initial begin
    rst      = 1'b0;
    fta_resp = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]      = '0;
      req[i].tid  = {4'(i), 4'hA};
      req[i].adr  = 32'h1000_0000 + 32'(i);
      req0[i]     = '0;
      req0[i].tid = {4'(i), 4'hB};
      req0[i].adr = 32'h2000_0000 + 32'(i);
    end
    tick();
    tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_fta_req", fta_req, 187'd0);
    chk("rst_stray", stray_cnt, 16'd0);
    chk("rst_rty", rty_vec(), 4'b1111);
    chk("rst_tid_echo", resp[1].tid, 8'h1A);
    rst = 1'b1;
    tick();

    // Round robin with single-cycle bursts from all four channels.
    set_cyc(4'b1111);
    tick();
    chk("rr_first", gnt, 4'b0001);
    chk("rr_first_adr", fta_req.adr, 32'h1000_0000);
    chk("rr_first_rty", rty_vec(), 4'b1110);
    exp_g = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_cyc(4'b1111 & ~exp_g);
      tick();
      exp_g = {exp_g[2:0], exp_g[3]};
      chk("rr_step", gnt, exp_g);
      set_cyc(4'b1111);
      tick();
      chk("rr_hold", gnt, exp_g);
    end
    chk("rr_wrap_adr", fta_req.adr, 32'h1000_0000);
    set_cyc(4'b0000);
    tick();
    chk("rr_idle", gnt, 4'b0000);
    chk("rr_idle_req", fta_req, 187'd0);

    // Hold limit: channel 0 bursts, channel 2 waits 16 grant cycles.
    set_cyc(4'b0001);
    tick();
    chk("hold_g0", gnt, 4'b0001);
    set_cyc(4'b0101);
    repeat (15) tick();
    chk("hold_g0_15", gnt, 4'b0001);
    tick();
    chk("hold_g2", gnt, 4'b0100);
    chk("hold_g2_adr", fta_req.adr, 32'h1000_0002);
    repeat (15) tick();
    chk("hold_g2_15", gnt, 4'b0100);
    tick();
    chk("hold_regrant0", gnt, 4'b0001);
    set_cyc(4'b0000);
    tick();
    chk("hold_idle", gnt, 4'b0000);

    // Fixed priority: channels 1 and 3 collide.
    set_cyc0(4'b1010);
    tick();
    chk("fp_g1", gnt0, 4'b0010);
    chk("fp_rty3", resp0[3].rty, 1'b1);
    repeat (3) tick();
    chk("fp_g1_held", gnt0, 4'b0010);
    chk("fp_rty3_held", resp0[3].rty, 1'b1);
    set_cyc0(4'b1000);
    tick();
    chk("fp_g3", gnt0, 4'b1000);
    chk("fp_rty3_gnt", resp0[3].rty, 1'b0);
    chk("fp_rty1", resp0[1].rty, 1'b1);
    set_cyc0(4'b0000);
    tick();

    // Routed response to channel 2 with one cycle of latency.
    fta_resp.ack = 1'b1;
    fta_resp.tid = 8'h25;
    fta_resp.dat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    #1;
    chk("rsp_latency", ack_vec(), 4'b0000);
    tick();
    chk("rsp_ack2", ack_vec(), 4'b0100);
    chk("rsp_dat2", resp[2].dat, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    chk("rsp_tid2", resp[2].tid, 8'h25);
    chk("rsp_tid0_echo", resp[0].tid, 8'h0A);
    fta_resp = '0;
    tick();
    chk("rsp_clear", ack_vec(), 4'b0000);

    // Stray response to nonexistent channel 6.
    chk("stray_0", stray_cnt, 16'd0);
    fta_resp.ack = 1'b1;
    fta_resp.tid = 8'h61;
    tick();
    chk("stray_noack", ack_vec(), 4'b0000);
    fta_resp = '0;
    tick();
    chk("stray_1", stray_cnt, 16'd1);
    tick();
    chk("stray_1_stable", stray_cnt, 16'd1);

    // Channel 1 burst, retry forwarded to the owner, then reset mid-burst.
    set_cyc(4'b0010);
    tick();
    chk("burst_g1", gnt, 4'b0010);
    chk("burst_adr", fta_req.adr, 32'h1000_0001);
    fta_resp.rty = 1'b1;
    fta_resp.tid = 8'h13;
    tick();
    chk("own_rty", resp[1].rty, 1'b1);
    fta_resp = '0;
    tick();
    chk("own_rty_clear", resp[1].rty, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_gnt", gnt, 4'b0000);
    chk("rst_mid_req", fta_req, 187'd0);
    chk("rst_mid_stray", stray_cnt, 16'd0);
    chk("rst_mid_rty", rty_vec(), 4'b1111);
    set_cyc(4'b1000);
    tick();
    rst = 1'b1;
    tick();
    chk("after_rst_g3", gnt, 4'b1000);
    chk("after_rst_adr", fta_req.adr, 32'h1000_0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fta_arbiter.md
FTA_ARBITER -- requirements
Module: fta_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of requesting master channels (2..8).
REQ-002 SHALL have parameter MODE, default 1, meaning 0 = fixed priority (channel 0 highest), 1 = round robin.
REQ-003 SHALL have parameter MAXHOLD, default 16, meaning maximum consecutive grant cycles before forced re-arbitration when others request (0 = unlimited).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  fta_cmd_request128_t[NCH]  per-channel master requests.
REQ-007 SHALL have port resp  output  fta_cmd_response128_t[NCH]  per-channel responses, including retry.
REQ-008 SHALL have port fta_req  output  fta_cmd_request128_t  request to the external bus.
REQ-009 SHALL have port fta_resp  input  fta_cmd_response128_t  response from the external bus.
REQ-010 SHALL have port gnt  output  NCH  one-hot current grant.
REQ-011 SHALL have port stray_cnt  output  16  count of responses whose tid.channel is >= NCH.

Function
REQ-012 SHALL implement states IDLE and GRANT; reset enters IDLE.
REQ-013 IDLE: when any req[i].cyc is high, the arbiter SHALL select a winner per MODE, load gnt, and enter GRANT on the next edge.
REQ-014 In GRANT, fta_req SHALL equal req[g] combinationally, where g is the granted channel; in IDLE, fta_req SHALL be all zeros.
REQ-015 Grant SHALL be held while req[g].cyc stays high (burst lock); deassertion of req[g].cyc SHALL re-arbitrate in the same cycle among the other requesters, or return to IDLE if there are none.
REQ-016 A hold counter SHALL increment each GRANT cycle. When the counter reaches MAXHOLD (MAXHOLD != 0) and any other channel requests, the grant SHALL move to the next winner on the following edge, and the counter SHALL clear.
REQ-017 Round robin: the search SHALL start at channel g+1, modulo NCH, after each grant; the pointer SHALL wrap from NCH-1 to 0.
REQ-018 Fixed priority: the lowest-numbered requesting channel SHALL win; forced rotation per REQ-016 SHALL still pick the lowest-numbered requester other than g.
REQ-019 Every channel other than g SHALL see resp[i].rty = 1; the granted channel's rty SHALL equal fta_resp.rty when fta_resp targets it, else 0.
REQ-020 For non-routed channels, resp[i].tid SHALL echo req[i].tid.
REQ-021 Response routing: fta_resp SHALL be registered one cycle, then presented on resp[c] where c = tid.channel, with all other fields passed unchanged; other channels SHALL get zeros apart from rty and tid.
REQ-022 A registered response with ack high and tid.channel >= NCH SHALL be dropped, and stray_cnt SHALL increment, saturating at 16'hFFFF.
REQ-023 Responses SHALL be routed regardless of the current grant, so split transactions complete after a grant changes.
REQ-024 A simultaneous grant release and new request from the same channel SHALL be treated as a new arbitration, and in MODE 1 that channel SHALL have lowest priority.
REQ-025 Latency SHALL be: req cyc in cycle N → fta_req driven in cycle N+1; fta_resp in cycle M → resp[c] in cycle M+1.

Reset
REQ-026 While rst is low, the block SHALL hold state = IDLE, gnt = 0, fta_req = 0, round-robin pointer = 0, hold counter = 0, stray_cnt = 0, the response register cleared, and resp[i].rty = 1 for all i.
REQ-027 Reset asserted mid-burst SHALL abort the grant immediately, with no partial request held; the first grant after release SHALL follow REQ-013.

Verification
REQ-028 Bench SHALL cover: NCH=4, MODE=1, channels 0..3 holding cyc with single-cycle bursts → gnt sequence 0001,0010,0100,1000,0001.
REQ-029 Bench SHALL cover: MODE=0, channels 1 and 3 request at once → gnt=0010, and channel 3 sees rty=1 until channel 1 drops cyc.
REQ-030 Bench SHALL cover: MAXHOLD=16, channel 0 holds cyc 40 cycles and channel 2 requests → grant moves to channel 2 after 16 GRANT cycles, and channel 0 is regranted later.
REQ-031 Bench SHALL cover: fta_resp ack with tid.channel=2 → resp[2].ack=1 one cycle later, and no other channel gets ack.
REQ-032 Bench SHALL cover: fta_resp ack with tid.channel=6 at NCH=4 → no resp ack, and stray_cnt goes 0→1.
REQ-033 Bench SHALL cover: rst pulled low during a channel 1 burst → gnt=0 and fta_req=0 at once; after release with only channel 3 requesting → gnt=1000.
